// File: rtl/rd73_serial_eval.sv
// rd73_serial_eval
// Serial rd73 evaluator: counts the ones among seven operand bits by shifting
// them out one per cycle into a 3-bit accumulator. z2..z0 carry the count,
// so z0 is the odd parity of the operand (rd73f2).
//
// Handshake rules (both ports):
//   - A transfer happens on a rising edge where valid=1 and ready=1.
//   - The source holds valid and its data stable until that transfer.
//   - ready never depends combinationally on valid; every output here comes
//     straight from a register.
//
// With EARLY_EXIT=1 the evaluation also stops once no set bits remain in the
// shift register, so sparse operands finish sooner.

module rd73_serial_eval #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x0,
    input  logic       x1,
    input  logic       x2,
    input  logic       x3,
    input  logic       x4,
    input  logic       x5,
    input  logic       x6,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       z0,
    output logic       z1,
    output logic       z2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    // Datapath registers
    logic [6:0] shreg;
    logic [2:0] count;
    logic [2:0] index;

    // Registered outputs
    logic       in_ready_q;
    logic       out_valid_q;
    logic [2:0] z_q;

    // Values produced by the current SHIFT edge
    logic [6:0] shreg_shifted;
    logic [2:0] count_plus;
    logic       shift_last;

    assign shreg_shifted = {1'b0, shreg[6:1]};
    assign count_plus    = count + {2'b00, shreg[0]};

    // SHIFT ends after the seventh bit, or early once nothing is left to count.
    // Seven ones give a count of 7, which still fits the 3-bit accumulator.
    assign shift_last = (index == 3'd6) ||
                        (EARLY_EXIT && (shreg_shifted == 7'd0));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, count in SHIFT, wait for the consumer in DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load the operand on acceptance, then shift and accumulate.
    // The x inputs are only sampled in IDLE, so changes during SHIFT or DONE
    // cannot disturb the result in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= 7'd0;
            count <= 3'd0;
            index <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= {x6, x5, x4, x3, x2, x1, x0};
                        count <= 3'd0;
                        index <= 3'd0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg_shifted;
                    count <= count_plus;
                    index <= index + 3'd1;
                end
                default: begin
                    shreg <= shreg;
                    count <= count;
                    index <= index;
                end
            endcase
        end
    end

    // Output registers: follow the next state so the flags line up with the
    // state itself. z is loaded with the final count when entering DONE, held
    // while the consumer stalls, and forced to 0 outside DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            z_q         <= 3'd0;
        end else begin
            in_ready_q  <= (state_next == IDLE);
            out_valid_q <= (state_next == DONE);
            if (state_next != DONE) begin
                z_q <= 3'd0;
            end else if (state == SHIFT) begin
                z_q <= count_plus;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z0        = z_q[0];
    assign z1        = z_q[1];
    assign z2        = z_q[2];
    assign state_dbg = state;

endmodule

// File: doc/rd73_serial_eval.md
RD73_SERIAL_EVAL -- requirements
Module: rd73_serial_eval

Interface
REQ-001 Parameter: EARLY_EXIT, default 0, meaning: when 1, evaluation ends as soon as no set bits remain in the shift register.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Ports: x0..x6  input  1 each  operand bits; x0 is the LSB.
REQ-005 Port: in_valid  input  1  operand x0..x6 is valid.
REQ-006 Port: in_ready  output  1  block accepts an operand.
REQ-007 Ports: z0, z1, z2  output  1 each  rd73 result, the count of ones among x0..x6; z0 is the LSB and equals odd parity (rd73f2).
REQ-008 Port: out_valid  output  1  z0..z2 hold a valid result.
REQ-009 Port: out_ready  input  1  consumer accepts the result.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 In IDLE, in_ready SHALL be 1, and in_ready SHALL be 0 in every other state.
REQ-012 An operand SHALL be accepted on a rising edge where the state is IDLE and in_valid=1.
REQ-013 On acceptance, the block SHALL capture x6..x0 into a 7-bit shift register, clear a 3-bit count, clear a 3-bit index, and move to SHIFT.
REQ-014 On each SHIFT edge, the block SHALL:
- add shift register bit 0 to the count;
- shift the register right by one, filling with 0;
- increment the index.
REQ-015 With EARLY_EXIT=0, SHIFT SHALL exit to DONE on the edge where index=6.
- out_valid therefore rises exactly 7 cycles after the accepting edge.
REQ-016 With EARLY_EXIT=1, SHIFT SHALL also exit to DONE on any edge where the post-shift register is 0.
- Minimum latency is 1 cycle (for example, an all-zero operand).
REQ-017 The count SHALL be 3 bits wide with a maximum value of 7; overflow SHALL be impossible and no saturation logic is required.
REQ-018 In DONE, out_valid SHALL be 1, and z2..z0 SHALL equal the final count and remain stable until the handshake completes.
REQ-019 A result handshake SHALL occur on an edge with out_valid=1 and out_ready=1; the FSM SHALL then go to IDLE.
- There is no IDLE bypass, so back-to-back throughput is one operand per 9 cycles (EARLY_EXIT=0).
REQ-020 While in DONE with out_ready=0, the block SHALL hold DONE and all outputs indefinitely.
REQ-021 x0..x6 SHALL be ignored in SHIFT and DONE; a change in those states SHALL NOT affect the in-flight result.
REQ-022 in_valid asserted while the block is not in IDLE SHALL NOT be accepted; the source holds its operand until in_ready=1.
REQ-023 out_ready asserted in IDLE or SHIFT SHALL have no effect.
REQ-024 z0..z2 SHALL be 0 whenever out_valid=0.
REQ-025 All outputs SHALL be driven directly from registers.
- No combinational path SHALL run from x0..x6 or in_valid to any output.

Reset
REQ-026 While rst=1, the block SHALL immediately force:
- state to IDLE;
- shift register, count and index to 0;
- out_valid=0 and z0=z1=z2=0;
- in_ready=1.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL discard the operation, and no result SHALL be emitted for it.
REQ-028 After rst deasserts, the first rising edge with in_valid=1 SHALL accept an operand.

Verification
REQ-029 EARLY_EXIT=0, operand x6..x0=1011011, out_ready=1 -> out_valid=1 exactly 7 cycles after acceptance, z2z1z0=101 (5), z0=1.
REQ-030 EARLY_EXIT=0, operands 0000000 then 1111111 sent back-to-back -> results 000 then 111, with second acceptance 9 cycles after the first.
REQ-031 EARLY_EXIT=1, operand 0000100 -> out_valid 3 cycles after acceptance, z=001; operand 0000000 -> out_valid 1 cycle after acceptance, z=000.
REQ-032 Backpressure: out_ready=0 for 20 cycles in DONE with x changing every cycle -> z, out_valid=1 and in_ready=0 are all held stable, and the result completes on the first edge with out_ready=1.
REQ-033 Reset: assert rst at the 3rd SHIFT cycle -> outputs go to reset values immediately; the next operand 0100001 yields z=010 with normal latency.
REQ-034 Exhaustive: all 128 operands with random out_ready stalls -> z2..z0 equals the popcount, z0 equals the 7-input XOR, and no result is dropped or duplicated.
